serial_frame_counter: RTL and testbench

Parametrised serial-to-parallel collector: a DATA_W-bit shift register paired with a loadable CNT_W-bit bit counter.
- Each enabled cycle shifts one serial bit in and advances the counter.
- On counter terminal count, the shift register is captured into a holding register and flagged valid until acknowledged.
- Sits between the serial input pin and the control FSM of the serial receiver datapath. Generalises the fixed 3-bit counter / 8-bit shifter pair with width, shift direction, frame length and a valid/ack handshake.

---
 rtl/serial_frame_counter.sv | 105 ++++++++++
 tb/tb_serial_frame_counter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_counter.sv
// Serial-to-parallel frame collector: shift register, loadable bit counter,
// captured frame with valid/ack handshake; optional parity via PARITY_CHECK_EN.
module serial_frame_counter #(
    parameter int DATA_W    = 8,
    parameter int CNT_W     = 3,
    parameter int LSB_FIRST = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              serin,
    input  logic              cnt_en,
    input  logic              ld_cnt,
    input  logic [CNT_W-1:0]  ld_val,
    output logic [CNT_W-1:0]  cnt_out,
    output logic              co,
    output logic [DATA_W-1:0] shift_out,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ack,
    output logic              overrun,
    output logic              parity_err
);

    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_nxt;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic              ovr_q;
    logic              cap;

    assign co  = cnt_en & (&cnt_q);
    assign cap = co & ~ld_cnt;

    generate
        if (LSB_FIRST != 0) begin : g_lsb
            assign shift_nxt = {serin, shift_q[DATA_W-1:1]};
        end else begin : g_msb
            assign shift_nxt = {shift_q[DATA_W-2:0], serin};
        end
    endgenerate

    // Bit counter and shift register; a load wins over a shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else if (ld_cnt) begin
            cnt_q <= ld_val;
        end else if (cnt_en) begin
            cnt_q   <= cnt_q + CNT_W'(1);
            shift_q <= shift_nxt;
        end
    end

    // Frame capture, valid/ack handshake and sticky overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else if (cap) begin
            data_q  <= shift_nxt;
            valid_q <= 1'b1;
            if (valid_q && !data_ack) begin
                ovr_q <= 1'b1;
            end
        end else if (valid_q && data_ack) begin
            valid_q <= 1'b0;
        end
    end

`ifdef PARITY_CHECK_EN
    logic par_q;
    logic perr_q;

    // Running parity of the current frame; latched into parity_err on capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_q  <= 1'b0;
            perr_q <= 1'b0;
        end else if (ld_cnt) begin
            par_q <= 1'b0;
        end else if (cnt_en) begin
            if (cap) begin
                perr_q <= par_q ^ serin;
                par_q  <= 1'b0;
            end else begin
                par_q <= par_q ^ serin;
            end
        end
    end

    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

    assign cnt_out    = cnt_q;
    assign shift_out  = shift_q;
    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_serial_frame_counter.sv
// Bench for serial_frame_counter: MSB-first and LSB-first instances driven in
// parallel, checked every cycle against a bit-history reference model.
module tb_serial_frame_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       serin;
    logic       cnt_en;
    logic       ld_cnt;
    logic [2:0] ld_val;
    logic       data_ack;

    logic [2:0] cnt0, cnt1;
    logic       co0, co1;
    logic [7:0] so0, so1, do0, do1;
    logic       dv0, dv1, ov0, ov1, pe0, pe1;

    int nchecks = 0;
    int nerr    = 0;

    serial_frame_counter #(.DATA_W(8), .CNT_W(3), .LSB_FIRST(0)) dut0 (
        .clk(clk), .rst(rst), .serin(serin), .cnt_en(cnt_en),
        .ld_cnt(ld_cnt), .ld_val(ld_val), .cnt_out(cnt0), .co(co0),
        .shift_out(so0), .data_out(do0), .data_valid(dv0),
        .data_ack(data_ack), .overrun(ov0), .parity_err(pe0)
    );

    serial_frame_counter #(.DATA_W(8), .CNT_W(3), .LSB_FIRST(1)) dut1 (
        .clk(clk), .rst(rst), .serin(serin), .cnt_en(cnt_en),
        .ld_cnt(ld_cnt), .ld_val(ld_val), .cnt_out(cnt1), .co(co1),
        .shift_out(so1), .data_out(do1), .data_valid(dv1),
        .data_ack(data_ack), .overrun(ov1), .parity_err(pe1)
    );

    always #5 clk = ~clk;

    // Reference model: full bit history, frame ones count, captured values.
    bit         hist[$];
    int         m_cnt;
    int         m_ones;
    bit         m_dv, m_ovr, m_perr;
    logic [7:0] m_do[2];
    bit         armed = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] shape(input int lsb);
        logic [7:0] v;
        int n;
        v = '0;
        n = hist.size();
        if (n >= 8) begin
            for (int i = 0; i < 8; i++) begin
                if (lsb != 0) v[7-i] = hist[n-1-i];
                else          v[i]   = hist[n-1-i];
            end
        end
        return v;
    endfunction

    task automatic model_step();
        bit cap;
        cap = 0;
        if (rst) begin
            hist.delete();
            for (int i = 0; i < 8; i++) hist.push_back(1'b0);
            m_cnt = 0; m_ones = 0;
            m_dv = 0; m_ovr = 0; m_perr = 0;
            m_do[0] = '0; m_do[1] = '0;
            armed = 1;
            return;
        end
        if (ld_cnt) begin
            m_cnt  = int'(ld_val);
            m_ones = 0;
        end else if (cnt_en) begin
            hist.push_back(serin);
            if (hist.size() > 8) void'(hist.pop_front());
            m_ones += int'(serin);
            cap = (m_cnt == 7);
            m_cnt = (m_cnt + 1) % 8;
        end
        if (cap) begin
            m_do[0] = shape(0);
            m_do[1] = shape(1);
            if (m_dv && !data_ack) m_ovr = 1;
            m_dv = 1;
`ifdef PARITY_CHECK_EN
            m_perr = (m_ones % 2) != 0;
`endif
            m_ones = 0;
        end else if (m_dv && data_ack) begin
            m_dv = 0;
        end
    endtask

    task automatic cmp_dut(input int k, input logic [2:0] c, input logic co,
                           input logic [7:0] so, input logic [7:0] dout,
                           input logic dv, input logic ov, input logic pe);
        chk($sformatf("cnt%0d", k), 32'(c), 32'(m_cnt));
        chk($sformatf("co%0d", k), 32'(co), 32'(cnt_en && m_cnt == 7));
        chk($sformatf("shift%0d", k), 32'(so), 32'(shape(k)));
        chk($sformatf("data%0d", k), 32'(dout), 32'(m_do[k]));
        chk($sformatf("valid%0d", k), 32'(dv), 32'(m_dv));
        chk($sformatf("overrun%0d", k), 32'(ov), 32'(m_ovr));
        chk($sformatf("parity%0d", k), 32'(pe), 32'(m_perr));
    endtask

    // Compare against the model mid-cycle, then advance it for the next edge.
    initial begin
        forever begin
            @(negedge clk);
            if (armed) begin
                cmp_dut(0, cnt0, co0, so0, do0, dv0, ov0, pe0);
                cmp_dut(1, cnt1, co1, so1, do1, dv1, ov1, pe1);
            end
            model_step();
        end
    end

    task automatic set(input logic r, input logic l, input logic [2:0] lv,
                       input logic e, input logic s, input logic a);
        rst = r; ld_cnt = l; ld_val = lv; cnt_en = e; serin = s; data_ack = a;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set(1, 0, 0, 0, 0, 0); tick();
        set(0, 0, 0, 0, 0, 0);
    endtask

    task automatic frame(input logic [7:0] v, input logic ack_last);
        set(0, 1, 0, 0, 0, 0); tick();
        for (int i = 0; i < 8; i++) begin
            set(0, 0, 0, 1, v[7-i], (i == 7) ? ack_last : 1'b0);
            tick();
        end
        set(0, 0, 0, 0, 0, 0);
    endtask

    logic [7:0] b2  = 8'b1011_0010;
    logic [4:0] b3  = 5'b11010;
    logic [7:0] b6  = 8'b0100_1101;
    logic       pe3;

    initial begin
`ifdef PARITY_CHECK_EN
        pe3 = 1'b1;
`else
        pe3 = 1'b0;
`endif
        // Reset with activity on the inputs, then idle.
        set(1, 0, 0, 1, 1, 0);
        tick(); tick();
        chk("t1_cnt", 32'(cnt0), 0);
        chk("t1_shift", 32'(so0), 0);
        chk("t1_valid", 32'(dv0), 0);
        set(0, 0, 0, 0, 0, 0);
        tick(); tick(); tick();
        chk("t1_idle_cnt", 32'(cnt0), 0);
        chk("t1_idle_data", 32'(do0), 0);

        // Full MSB-first frame.
        set(0, 1, 0, 0, 0, 0); tick();
        for (int i = 0; i < 8; i++) begin
            set(0, 0, 0, 1, b2[7-i], 0);
            #1;
            chk("t2_co", 32'(co0), 32'(i == 7));
            tick();
        end
        set(0, 0, 0, 0, 0, 0);
        chk("t2_data", 32'(do0), 32'h00b2);
        chk("t2_model", 32'(m_do[0]), 32'h00b2);
        chk("t2_valid", 32'(dv0), 1);
        chk("t2_cnt", 32'(cnt0), 0);
        chk("t2_parity", 32'(pe0), 0);

        // Short frame from a loaded count.
        set(0, 1, 3, 0, 0, 0); tick();
        for (int i = 0; i < 5; i++) begin
            chk("t3_cnt", 32'(cnt0), 32'(3 + i));
            set(0, 0, 0, 1, b3[4-i], 0);
            tick();
        end
        set(0, 0, 0, 0, 0, 0);
        chk("t3_cnt_wrap", 32'(cnt0), 0);
        chk("t3_data", 32'(do0[4:0]), 32'h1a);
        chk("t3_parity", 32'(pe0), 32'(pe3));

        // Overrun without ack, then ack on the capture edge.
        do_reset();
        frame(8'h5c, 0);
        frame(8'he1, 0);
        chk("t4_data", 32'(do0), 32'h00e1);
        chk("t4_overrun", 32'(ov0), 1);
        do_reset();
        frame(8'h5c, 0);
        frame(8'he1, 1);
        chk("t4b_overrun", 32'(ov0), 0);
        chk("t4b_valid", 32'(dv0), 1);
        chk("t4b_data", 32'(do0), 32'h00e1);

        // Load beats shift; reset mid-frame.
        do_reset();
        set(0, 1, 0, 0, 0, 0); tick();
        set(0, 0, 0, 1, 1, 0); tick();
        set(0, 0, 0, 1, 0, 0); tick();
        set(0, 0, 0, 1, 1, 0); tick();
        set(0, 0, 0, 1, 1, 0); tick();
        chk("t5_cnt4", 32'(cnt0), 4);
        set(0, 1, 5, 1, 1, 0); tick();
        chk("t5_ld_cnt", 32'(cnt0), 5);
        chk("t5_ld_shift", 32'(so0), 32'h000b);
        set(0, 1, 0, 0, 0, 0); tick();
        for (int i = 0; i < 4; i++) begin
            set(0, 0, 0, 1, 1, 0); tick();
        end
        chk("t5_cnt4b", 32'(cnt0), 4);
        set(1, 0, 0, 1, 1, 0); tick();
        chk("t5_rst_cnt", 32'(cnt0), 0);
        chk("t5_rst_shift", 32'(so0), 0);
        set(0, 0, 0, 0, 0, 0);

        // LSB-first frame on the second instance.
        do_reset();
        set(0, 1, 0, 0, 0, 0); tick();
        for (int i = 0; i < 8; i++) begin
            set(0, 0, 0, 1, b6[7-i], 0);
            tick();
        end
        set(0, 0, 0, 0, 0, 0);
        chk("t6_data", 32'(do1), 32'h00b2);
        chk("t6_model", 32'(m_do[1]), 32'h00b2);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            set(($urandom_range(0, 199) == 0),
                ($urandom_range(0, 19) == 0),
                3'($urandom),
                ($urandom_range(0, 9) < 7),
                1'($urandom),
                ($urandom_range(0, 3) == 0));
            tick();
        end
        set(0, 0, 0, 0, 0, 0);
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
